// File: rtl/cflog_pkg.sv
// Shared types and constants for the CF-Log speculation expander.
// Imported by the expander, its output register and the logger FIFO path.
package cflog_pkg;

  localparam logic [15:0] MARKER      = 16'h1111;
  localparam int          ADDR_W      = 16;
  localparam int          CTR_W       = 32;
  localparam int          ENTRY_BYTES = 4;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ENTRY_BYTES);

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dest;
  } cflog_entry_t;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOG_RD   = 4'd1,
    S_LOG_WAIT = 4'd2,
    S_CHECK    = 4'd3,
    S_CNT_RD   = 4'd4,
    S_CNT_WAIT = 4'd5,
    S_DIR_RD   = 4'd6,
    S_DIR_WAIT = 4'd7,
    S_BLK_RD   = 4'd8,
    S_BLK_WAIT = 4'd9,
    S_EMIT_LOG = 4'd10,
    S_EMIT_BLK = 4'd11,
    S_DONE     = 4'd12,
    S_ERR      = 4'd13
  } cflog_state_e;

  function automatic logic [ADDR_W-1:0] blk_addr(
    input logic [ADDR_W-1:0] base,
    input logic [7:0]        idx
  );
    return base + ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/cflog_out_reg.sv
// Single-entry valid/ready output register for expanded CF-Log entries.
// Holds its entry until the downstream accepts it.
module cflog_out_reg
  import cflog_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  cflog_entry_t ld_entry,
  input  logic         ld_spec,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [15:0]  out_src,
  output logic [15:0]  out_dest,
  output logic         out_spec,
  output logic         acc
);

  logic         valid_q, valid_d;
  cflog_entry_t ent_q, ent_d;
  logic         spec_q, spec_d;

  assign acc = valid_q & out_ready;

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    spec_d  = spec_q;
    if (acc) begin
      valid_d = 1'b0;
    end
    if (ld) begin
      valid_d = 1'b1;
      ent_d   = ld_entry;
      spec_d  = ld_spec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
      spec_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      spec_q  <= spec_d;
    end
  end

  assign out_valid = valid_q;
  assign out_src   = ent_q.src;
  assign out_dest  = ent_q.dest;
  assign out_spec  = spec_q;

endmodule

// File: rtl/cflog_expand.sv
// Walks a compressed CF-Log and re-expands speculation markers into
// the full entry sequence of the referenced block.
module cflog_expand
  import cflog_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] log_base,
  input  logic [ADDR_W-1:0] log_end,
  output logic              log_rd_en,
  output logic [ADDR_W-1:0] log_rd_addr,
  input  logic [31:0]       log_rd_data,
  output logic              dir_rd_en,
  output logic [7:0]        dir_rd_id,
  input  logic              dir_rd_hit,
  input  logic [ADDR_W-1:0] dir_rd_base,
  input  logic [7:0]        dir_rd_len,
  output logic              blk_rd_en,
  output logic [ADDR_W-1:0] blk_rd_addr,
  input  logic [31:0]       blk_rd_data,
  output logic              out_valid,
  output logic [15:0]       out_src,
  output logic [15:0]       out_dest,
  output logic              out_spec,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       entries_out
);

  cflog_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] mptr_q, mptr_d;
  logic [7:0]        id_q, id_d;
  logic [CTR_W-1:0]  reps_q, reps_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  cflog_entry_t      word_q, word_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              ld;
  cflog_entry_t      ld_e;
  logic              ld_spec;
  logic              acc;
  logic [ADDR_W-1:0] ptr_nx;
  cflog_entry_t      cw;
  logic              more_idx;

  assign ptr_nx   = ptr_q + STRIDE;
  assign cw       = log_rd_data;
  assign more_idx = ({1'b0, idx_q} + 9'd1) < {1'b0, len_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    mptr_d  = mptr_q;
    id_d    = id_q;
    reps_d  = reps_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    error_d = error_q;
    eaddr_d = eaddr_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    ld_e    = word_q;
    ld_spec = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = log_base;
          end_d   = log_end;
          error_d = 1'b0;
          eaddr_d = '0;
          cnt_d   = '0;
          state_d = (log_base >= log_end) ? S_DONE : S_LOG_RD;
        end
      end
      S_LOG_RD: state_d = S_LOG_WAIT;
      S_LOG_WAIT: begin
        word_d  = log_rd_data;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (word_q.src != MARKER) begin
          ld      = 1'b1;
          ld_e    = word_q;
          state_d = S_EMIT_LOG;
        end else begin
          id_d   = word_q.dest[7:0];
          mptr_d = ptr_q;
          ptr_d  = ptr_nx;
          if (ptr_nx < end_q) begin
            state_d = S_CNT_RD;
          end else begin
            reps_d  = CTR_W'(1);
            state_d = S_DIR_RD;
          end
        end
      end
      S_CNT_RD: state_d = S_CNT_WAIT;
      S_CNT_WAIT: begin
        // A non-zero src means no count word; leave it for the log walk.
        if (cw.src == 16'h0000) begin
          if (cw == '0) begin
            error_d = 1'b1;
            eaddr_d = ptr_q;
            state_d = S_ERR;
          end else begin
            reps_d  = cw;
            ptr_d   = ptr_nx;
            state_d = S_DIR_RD;
          end
        end else begin
          reps_d  = CTR_W'(1);
          state_d = S_DIR_RD;
        end
      end
      S_DIR_RD: state_d = S_DIR_WAIT;
      S_DIR_WAIT: begin
        if (!dir_rd_hit || dir_rd_len == 8'd0) begin
          error_d = 1'b1;
          eaddr_d = mptr_q;
          state_d = S_ERR;
        end else begin
          base_d  = dir_rd_base;
          len_d   = dir_rd_len;
          idx_d   = 8'd0;
          state_d = S_BLK_RD;
        end
      end
      S_BLK_RD: state_d = S_BLK_WAIT;
      S_BLK_WAIT: begin
        ld      = 1'b1;
        ld_e    = blk_rd_data;
        ld_spec = 1'b1;
        state_d = S_EMIT_BLK;
      end
      S_EMIT_LOG: begin
        if (acc) begin
          ptr_d   = ptr_nx;
          state_d = (ptr_nx >= end_q) ? S_DONE : S_LOG_RD;
        end
      end
      S_EMIT_BLK: begin
        if (acc) begin
          if (more_idx) begin
            idx_d   = idx_q + 8'd1;
            state_d = S_BLK_RD;
          end else if (reps_q > CTR_W'(1)) begin
            reps_d  = reps_q - CTR_W'(1);
            idx_d   = 8'd0;
            state_d = S_BLK_RD;
          end else begin
            state_d = (ptr_q >= end_q) ? S_DONE : S_LOG_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (acc) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      mptr_q  <= '0;
      id_q    <= '0;
      reps_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      error_q <= 1'b0;
      eaddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      mptr_q  <= mptr_d;
      id_q    <= id_d;
      reps_q  <= reps_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      error_q <= error_d;
      eaddr_q <= eaddr_d;
      cnt_q   <= cnt_d;
    end
  end

  cflog_out_reg u_out (
    .clk       (clk),
    .reset     (reset),
    .ld        (ld),
    .ld_entry  (ld_e),
    .ld_spec   (ld_spec),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_src   (out_src),
    .out_dest  (out_dest),
    .out_spec  (out_spec),
    .acc       (acc)
  );

  // Addresses are gated so reset drives every memory port to zero.
  assign log_rd_en   = (state_q == S_LOG_RD) || (state_q == S_CNT_RD);
  assign log_rd_addr = log_rd_en ? ptr_q : '0;
  assign dir_rd_en   = (state_q == S_DIR_RD);
  assign dir_rd_id   = dir_rd_en ? id_q : '0;
  assign blk_rd_en   = (state_q == S_BLK_RD);
  assign blk_rd_addr = blk_rd_en ? blk_addr(base_q, idx_q) : '0;

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) &&
                       (state_q != S_ERR);
  assign done        = (state_q == S_DONE);
  assign error       = error_q;
  assign err_addr    = eaddr_q;
  assign entries_out = cnt_q;

endmodule

// File: tb/tb_cflog_expand.sv
// Randomized and directed bench for cflog_expand against a
// loop-based model of the compressed log format.
module tb_cflog_expand;

  localparam logic [15:0] MK = 16'h1111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] log_base = '0;
  logic [15:0] log_end = '0;
  logic        log_rd_en;
  logic [15:0] log_rd_addr;
  logic [31:0] log_rd_data = '0;
  logic        dir_rd_en;
  logic [7:0]  dir_rd_id;
  logic        dir_rd_hit = 1'b0;
  logic [15:0] dir_rd_base = '0;
  logic [7:0]  dir_rd_len = '0;
  logic        blk_rd_en;
  logic [15:0] blk_rd_addr;
  logic [31:0] blk_rd_data = '0;
  logic        out_valid;
  logic [15:0] out_src;
  logic [15:0] out_dest;
  logic        out_spec;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] err_addr;
  logic [15:0] entries_out;

  cflog_expand dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .log_base    (log_base),
    .log_end     (log_end),
    .log_rd_en   (log_rd_en),
    .log_rd_addr (log_rd_addr),
    .log_rd_data (log_rd_data),
    .dir_rd_en   (dir_rd_en),
    .dir_rd_id   (dir_rd_id),
    .dir_rd_hit  (dir_rd_hit),
    .dir_rd_base (dir_rd_base),
    .dir_rd_len  (dir_rd_len),
    .blk_rd_en   (blk_rd_en),
    .blk_rd_addr (blk_rd_addr),
    .blk_rd_data (blk_rd_data),
    .out_valid   (out_valid),
    .out_src     (out_src),
    .out_dest    (out_dest),
    .out_spec    (out_spec),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_addr    (err_addr),
    .entries_out (entries_out)
  );

  always #5 clk = ~clk;

  logic [31:0] logm [0:1023];
  logic [31:0] blkm [0:1023];
  logic        dhit [0:255];
  logic [15:0] dbase [0:255];
  logic [7:0]  dlen [0:255];

  always @(posedge clk) begin
    if (log_rd_en) log_rd_data <= logm[log_rd_addr[11:2]];
    if (dir_rd_en) begin
      dir_rd_hit  <= dhit[dir_rd_id];
      dir_rd_base <= dbase[dir_rd_id];
      dir_rd_len  <= dlen[dir_rd_id];
    end
    if (blk_rd_en) blk_rd_data <= blkm[blk_rd_addr[11:2]];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] got_v,
                     input logic [127:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got_v, exp_v);
    end
  endtask

  int rmode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [32:0] got_q[$];
  int cyc = 0;
  int nrd = 0;
  int ndone = 0;
  int first_rd = -1;
  int first_vld = -1;
  logic        stall_p = 1'b0;
  logic [32:0] hold_v = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (log_rd_en | dir_rd_en | blk_rd_en) nrd++;
    if (log_rd_en && first_rd < 0) first_rd = cyc;
    if (out_valid && first_vld < 0) first_vld = cyc;
    if (done) ndone++;
    if (stall_p && reset)
      chk("hold", {out_valid, out_src, out_dest, out_spec}, {1'b1, hold_v});
    if (out_valid && out_ready)
      got_q.push_back({out_src, out_dest, out_spec});
    stall_p = reset && out_valid && !out_ready;
    hold_v  = {out_src, out_dest, out_spec};
  end

  logic [32:0] exp_q[$];
  logic        exp_err;
  logic [15:0] exp_ea;

  task automatic model(input logic [15:0] b, input logic [15:0] e);
    logic [15:0] p, mp, a;
    logic [31:0] w, c, reps;
    logic [7:0]  id;
    exp_q.delete();
    exp_err = 1'b0;
    exp_ea  = '0;
    p = b;
    while (p < e) begin
      w = logm[p[11:2]];
      if (w[31:16] != MK) begin
        exp_q.push_back({w, 1'b0});
        p = p + 16'd4;
      end else begin
        id = w[7:0];
        mp = p;
        p = p + 16'd4;
        reps = 1;
        if (p < e) begin
          c = logm[p[11:2]];
          if (c[31:16] == 16'h0000) begin
            if (c == 0) begin
              exp_err = 1'b1;
              exp_ea  = p;
              return;
            end
            reps = c;
            p = p + 16'd4;
          end
        end
        if (!dhit[id] || dlen[id] == 0) begin
          exp_err = 1'b1;
          exp_ea  = mp;
          return;
        end
        for (int unsigned r = 0; r < reps; r++)
          for (int i = 0; i < int'(dlen[id]); i++) begin
            a = dbase[id] + 16'(i * 4);
            exp_q.push_back({blkm[a[11:2]], 1'b1});
          end
      end
    end
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] e);
    log_base = b;
    log_end  = e;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic [15:0] b, input logic [15:0] e,
                     input int mode, input string nm, output int lat);
    bit fin;
    int n;
    model(b, e);
    rmode = mode;
    got_q.delete();
    ndone = 0;
    nrd = 0;
    first_rd = -1;
    first_vld = -1;
    pulse_start(b, e);
    fin = 0;
    lat = 0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      lat = k + 1;
      if (done || error) fin = 1;
    end
    if (!fin) chk({nm, " timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    chk({nm, " error"}, error, exp_err);
    if (exp_err) chk({nm, " err_addr"}, err_addr, exp_ea);
    chk({nm, " done_pulses"}, ndone, exp_err ? 0 : 1);
    chk({nm, " count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s ent%0d", nm, i), got_q[i], exp_q[i]);
    chk({nm, " entries_out"}, entries_out, 16'(exp_q.size()));
    chk({nm, " busy"}, busy, 0);
  endtask

  function automatic logic [127:0] outvec();
    return {out_valid, out_src, out_dest, out_spec, log_rd_en, log_rd_addr,
            dir_rd_en, dir_rd_id, blk_rd_en, blk_rd_addr, busy, done, error,
            err_addr, entries_out};
  endfunction

  initial begin
    int lat;
    int p;
    int k;
    int cnt;
    bit seen;
    for (int i = 0; i < 1024; i++) begin
      logm[i] = 32'hDEAD_0000 | 32'(i);
      blkm[i] = 32'hB000_0000 | 32'(i);
    end
    for (int i = 0; i < 256; i++) begin
      dhit[i] = 1'b0;
      dbase[i] = '0;
      dlen[i] = '0;
    end

    #2;
    chk("reset_state", outvec(), '0);
    @(negedge clk);
    reset = 1'b1;

    // plain entries
    logm[16'h0040 >> 2] = 32'hE010_E020;
    logm[16'h0044 >> 2] = 32'hE030_E040;
    logm[16'h0048 >> 2] = 32'hE050_E060;
    run(16'h0040, 16'h004C, 0, "plain", lat);
    chk("plain latency", first_vld - first_rd, 3);

    // single marker, next word not a count
    dhit[5] = 1'b1; dbase[5] = 16'h0100; dlen[5] = 8'd2;
    blkm[16'h0100 >> 2] = 32'hB001_B002;
    blkm[16'h0104 >> 2] = 32'hB003_B004;
    logm[16'h0080 >> 2] = 32'h1111_0005;
    logm[16'h0084 >> 2] = 32'hE070_E080;
    run(16'h0080, 16'h0088, 0, "marker", lat);

    // marker with repeat count 3
    dhit[3] = 1'b1; dbase[3] = 16'h0200; dlen[3] = 8'd2;
    blkm[16'h0200 >> 2] = 32'hA0A1_A0A2;
    blkm[16'h0204 >> 2] = 32'hB0B1_B0B2;
    logm[16'h00C0 >> 2] = 32'h1111_0003;
    logm[16'h00C4 >> 2] = 32'h0000_0003;
    run(16'h00C0, 16'h00C8, 0, "repeat", lat);
    run(16'h00C0, 16'h00C8, 1, "repeat_bp", lat);

    // directory miss at base+8
    logm[16'h0300 >> 2] = 32'hE0A0_E0B0;
    logm[16'h0304 >> 2] = 32'hE0C0_E0D0;
    logm[16'h0308 >> 2] = 32'h1111_0009;
    logm[16'h030C >> 2] = 32'hE0E0_E0E1;
    run(16'h0300, 16'h0310, 0, "dir_miss", lat);

    // zero repeat count
    logm[16'h0340 >> 2] = 32'h1111_0005;
    logm[16'h0344 >> 2] = 32'h0000_0000;
    run(16'h0340, 16'h0348, 0, "zero_cnt", lat);

    // empty log
    run(16'h0400, 16'h0400, 0, "empty", lat);
    chk("empty latency_ok", lat <= 2, 1);
    chk("empty reads", nrd, 0);

    // marker as last word
    logm[16'h0380 >> 2] = 32'hE0E0_E0F0;
    logm[16'h0384 >> 2] = 32'h1111_0003;
    run(16'h0380, 16'h0388, 2, "marker_last", lat);

    // reset while expanding a block
    rmode = 0;
    pulse_start(16'h00C0, 16'h00C8);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (out_valid && out_spec) seen = 1;
    end
    chk("rst_mid reached_block", seen, 1);
    #2 reset = 1'b0;
    #1 chk("rst_mid outputs", outvec(), '0);
    @(negedge clk);
    #1 reset = 1'b1;
    run(16'h00C0, 16'h00C8, 1, "after_rst", lat);

    // random logs
    for (int it = 0; it < 8; it++) begin
      for (int id = 8'h20; id <= 8'h28; id++) begin
        dhit[id]  = (id != 8'h28) && ($urandom_range(0, 7) != 0);
        dlen[id]  = 8'($urandom_range(0, 4));
        dbase[id] = 16'h0A00 + 16'((id - 8'h20) * 16'h20);
        for (int j = 0; j < 4; j++)
          blkm[(dbase[id] >> 2) + 16'(j)] = $urandom;
      end
      p = 16'h0800;
      for (int s = 0; s < int'($urandom_range(1, 10)); s++) begin
        k = $urandom_range(0, 5);
        if (k < 3) begin
          logm[p >> 2] = {4'hE, 12'($urandom), 16'($urandom)};
          p += 4;
        end else begin
          logm[p >> 2] = {MK, 8'h00, 8'(8'h20 + $urandom_range(0, 8))};
          p += 4;
          if (k == 5) begin
            cnt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            logm[p >> 2] = {16'h0000, 16'(cnt)};
            p += 4;
          end
        end
      end
      run(16'h0800, 16'(p), 2, $sformatf("rnd%0d", it), lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
